// File: rtl/loop_pkg.sv
// Shared types and header-field helpers for the acc_loop_mq loopback accelerator.
package loop_pkg;

   typedef enum logic [1:0] {
      ECHO    = 2'd0,
      FORWARD = 2'd1,
      SINK    = 2'd2,
      RSVD    = 2'd3
   } loop_mode_e;

   typedef enum logic [1:0] {
      IN_HDR  = 2'd0,
      IN_BODY = 2'd1,
      IN_DROP = 2'd2
   } in_state_e;

   // Header id fields, counted in units of one {Y,X} id (2*XY_SZ bits).
   localparam int DST_FIELD = 0;
   localparam int SRC_FIELD = 1;

   function automatic int field_lsb(input int field, input int xy_sz);
      return field * 2 * xy_sz;
   endfunction

   // The reserved mode behaves exactly like SINK.
   function automatic logic is_sink(input loop_mode_e m);
      return (m == SINK) || (m == RSVD);
   endfunction

endpackage

// File: rtl/loop_fifo.sv
// Synchronous flit FIFO: flop storage, output presented from the head entry,
// zero on the output while empty. No bypass, so a pop never frees a slot for a push in the same cycle.
module loop_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/acc_loop_mq.sv
// Loopback accelerator: buffers AXI-Stream packets, rewrites the header and returns them
// (ECHO/FORWARD) or discards them (SINK). Optional counters under macro LOOP_STATS_EN.
module acc_loop_mq
   import loop_pkg::*;
#(
   parameter int BW    = 32,
   parameter int XY_SZ = 3,
   parameter int DEPTH = 16
) (
   input  logic                 clk_line,
   input  logic                 clk_line_rst_low,
   input  logic [2*XY_SZ-1:0]   HsrcId,
   input  logic [1:0]           mode,
   input  logic [2*XY_SZ-1:0]   fwd_dst,
   input  logic                 stream_in_TVALID,
   output logic                 stream_in_TREADY,
   input  logic                 stream_in_TLAST,
   input  logic [BW-1:0]        stream_in_TDATA,
   input  logic [BW/8-1:0]      stream_in_TKEEP,
   output logic                 stream_out_TVALID,
   input  logic                 stream_out_TREADY,
   output logic                 stream_out_TLAST,
   output logic [BW-1:0]        stream_out_TDATA,
   output logic [BW/8-1:0]      stream_out_TKEEP,
`ifdef LOOP_STATS_EN
   output logic [31:0]          pkt_count,
   output logic [31:0]          drop_count,
`endif
   output logic                 busy,
   output logic [1:0]           in_state_dbg
);

   localparam int BWB     = BW / 8;
   localparam int AW      = $clog2(DEPTH);
   localparam int EW      = 1 + BWB + BW;
   localparam int ID_W    = 2 * XY_SZ;
   localparam int DST_LSB = field_lsb(DST_FIELD, XY_SZ);
   localparam int SRC_LSB = field_lsb(SRC_FIELD, XY_SZ);

   // Handshake rule on both streams: a flit moves on a rising clk_line edge where
   // TVALID && TREADY; a source holds TVALID and payload stable until that edge.

   in_state_e   state, state_nxt;
   loop_mode_e  mode_e;
   logic        in_hs;
   logic        discard;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [AW:0] fifo_count;
   logic [BW-1:0] hdr_new;
   logic [BW-1:0] wr_data;
   logic [EW-1:0] rd_entry;

   assign mode_e  = loop_mode_e'(mode);
   // Mode matters only at the header; afterwards the state carries the packet's fate.
   assign discard = (state == IN_DROP) || ((state == IN_HDR) && is_sink(mode_e));
   assign stream_in_TREADY = discard ? 1'b1 : !full;
   assign in_hs   = stream_in_TVALID && stream_in_TREADY;
   assign push    = in_hs && !discard;

   always_comb begin
      hdr_new = stream_in_TDATA;
      hdr_new[SRC_LSB +: ID_W] = HsrcId;
      if (mode_e == ECHO) hdr_new[DST_LSB +: ID_W] = stream_in_TDATA[SRC_LSB +: ID_W];
      else                hdr_new[DST_LSB +: ID_W] = fwd_dst;
   end

   assign wr_data = (state == IN_HDR) ? hdr_new : stream_in_TDATA;

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) state <= IN_HDR;
      else                   state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IN_HDR: begin
            if (in_hs && !stream_in_TLAST)
               state_nxt = is_sink(mode_e) ? IN_DROP : IN_BODY;
         end
         IN_BODY, IN_DROP: begin
            if (in_hs && stream_in_TLAST) state_nxt = IN_HDR;
         end
         default: state_nxt = IN_HDR;
      endcase
   end

   loop_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk_line),
      .rst_n (clk_line_rst_low),
      .push  (push),
      .wdata ({stream_in_TLAST, stream_in_TKEEP, wr_data}),
      .pop   (pop),
      .rdata (rd_entry),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign stream_out_TVALID = !empty;
   assign pop = stream_out_TVALID && stream_out_TREADY;
   assign {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} = rd_entry;

   assign busy         = (fifo_count != '0) || (state != IN_HDR);
   assign in_state_dbg = state;

`ifdef LOOP_STATS_EN
   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (push && stream_in_TLAST)                pkt_count  <= pkt_count + 32'd1;
         if (in_hs && discard && stream_in_TLAST)    drop_count <= drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_acc_loop_mq.sv
// Bench for acc_loop_mq: randomized packets against a packet-level reference model.
module tb_acc_loop_mq;
  localparam int BW    = 32;
  localparam int XY_SZ = 3;
  localparam int DEPTH = 16;
  localparam int BWB   = BW / 8;
  localparam int EW    = 1 + BWB + BW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*XY_SZ-1:0] hsrc_id, fwd_dst;
  logic [1:0]   mode;
  logic         in_valid, in_ready, in_last;
  logic [BW-1:0]  in_data;
  logic [BWB-1:0] in_keep;
  logic         out_valid, out_ready, out_last;
  logic [BW-1:0]  out_data;
  logic [BWB-1:0] out_keep;
  logic         busy;
  logic [1:0]   in_state_dbg;
`ifdef LOOP_STATS_EN
  logic [31:0]  pkt_count, drop_count;
`endif

  acc_loop_mq #(.BW(BW), .XY_SZ(XY_SZ), .DEPTH(DEPTH)) dut (
    .clk_line          (clk),
    .clk_line_rst_low  (rst_n),
    .HsrcId            (hsrc_id),
    .mode              (mode),
    .fwd_dst           (fwd_dst),
    .stream_in_TVALID  (in_valid),
    .stream_in_TREADY  (in_ready),
    .stream_in_TLAST   (in_last),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_out_TVALID (out_valid),
    .stream_out_TREADY (out_ready),
    .stream_out_TLAST  (out_last),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
`ifdef LOOP_STATS_EN
    .pkt_count         (pkt_count),
    .drop_count        (drop_count),
`endif
    .busy              (busy),
    .in_state_dbg      (in_state_dbg)
  );

  // scoreboard and reference model state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  int m_pkts = 0;
  int m_drops = 0;
  bit m_in_pkt = 0;
  bit m_pkt_sink = 0;
  bit in_fire = 0;
  bit prev_stall = 0;
  logic [EW-1:0] prev_got;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 never ready

  function automatic logic [BW-1:0] rewrite(input logic [BW-1:0] h);
    int unsigned old_src, new_dst, res;
    old_src = (h >> 6) & 32'h3F;
    new_dst = (mode == 2'd0) ? old_src : int'(fwd_dst);
    res = (h & ~32'hFFF) | (int'(hsrc_id) << 6) | new_dst;
    return res;
  endfunction

  // one clock cycle: check this cycle's outputs, update the model, advance
  task automatic cycle();
    logic [EW-1:0] got, exp;
    logic exp_rdy;
    bit disc;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = (rdy_mode == 0);
    #1;
    disc = m_in_pkt ? m_pkt_sink : (mode >= 2'd2);
    exp_rdy = disc ? 1'b1 : (exp_q.size() < DEPTH);
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_errors++;
      $display("FAIL in_tready: got %b expected %b (queued %0d)", in_ready, exp_rdy, exp_q.size());
    end
    n_checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      n_errors++;
      $display("FAIL out_tvalid: got %b expected %b", out_valid, exp_q.size() != 0);
    end
    got = {out_last, out_keep, out_data};
    if (prev_stall) begin
      n_checks++;
      if (out_valid !== 1'b1 || got !== prev_got) begin
        n_errors++;
        $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, got, prev_got);
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      n_out++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_extra: got %h expected no flit", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_errors++;
          $display("FAIL out_flit: got %h expected %h", got, exp);
        end
      end
    end
    in_fire = in_valid && (in_ready === 1'b1);
    if (in_fire) begin
      if (!m_in_pkt) begin
        m_pkt_sink = disc;
        m_in_pkt = !in_last;
        if (!disc) exp_q.push_back({in_last, in_keep, rewrite(in_data)});
      end else begin
        if (!m_pkt_sink) exp_q.push_back({in_last, in_keep, in_data});
        if (in_last) m_in_pkt = 0;
      end
      if (in_last) begin
        if (disc) m_drops++;
        else      m_pkts++;
      end
    end
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_got = got;
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: one packet, optional mode change right after the header
  task automatic send_pkt(input int n, input logic [BW-1:0] hdr, input logic [1:0] mode_mid);
    int budget;
    for (int i = 0; i < n; i++) begin
      in_data  = (i == 0) ? hdr : BW'($urandom);
      in_keep  = BWB'($urandom);
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      budget = 0;
      do begin
        cycle();
        budget++;
      end while (!in_fire && budget < 200);
      in_valid = 1'b0;
      if (!in_fire) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got no handshake expected flit %0d accepted", i);
        return;
      end
      if (i == 0) mode = mode_mid;
      if ($urandom_range(0, 3) == 0) cycle();
    end
  endtask

  task automatic drain();
    int budget;
    in_valid = 1'b0;
    if (rdy_mode == 2) rdy_mode = 1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      cycle();
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d flits pending expected 0", exp_q.size());
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, out_keep, out_data, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h busy=%b expected all 0",
               out_valid, out_last, out_keep, out_data, busy);
    end
    n_checks++;
    if (in_state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected 0", in_state_dbg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_echo();
    rdy_mode = 0;
    mode = 2'd0;
    send_pkt(3, 32'h0000_0A51, 2'd0);
    drain();
  endtask

  task automatic test_forward();
    mode = 2'd1;
    send_pkt(1, BW'($urandom), 2'd1);
    n_checks++;
    if (in_state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL single_flit_state: got %0d expected 0", in_state_dbg);
    end
    drain();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_sink();
    mode = 2'd2;
    send_pkt(4, BW'($urandom), 2'd2);
    send_pkt(4, BW'($urandom), 2'd2);
    cycle();
`ifdef LOOP_STATS_EN
    n_checks++;
    if (drop_count !== 32'(m_drops)) begin
      n_errors++;
      $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drops);
    end
`endif
  endtask

  task automatic test_full();
    int acc, b, out0;
    rdy_mode = 2;
    mode = 2'd1;
    acc = 0;
    out0 = n_out;
    in_valid = 1'b1; in_data = BW'($urandom); in_keep = BWB'($urandom); in_last = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (in_fire) begin
        acc++;
        in_data = BW'($urandom); in_keep = BWB'($urandom); in_last = (acc == 19);
      end
    end
    n_checks++;
    if (acc !== DEPTH) begin
      n_errors++;
      $display("FAIL full_accept: got %0d expected %0d", acc, DEPTH);
    end
    rdy_mode = 0;
    b = 0;
    while (acc < 20 && b < 200) begin
      cycle();
      b++;
      if (in_fire) begin
        acc++;
        if (acc < 20) begin
          in_data = BW'($urandom); in_keep = BWB'($urandom); in_last = (acc == 19);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    drain();
    n_checks++;
    if (n_out - out0 !== 20) begin
      n_errors++;
      $display("FAIL full_drain_count: got %0d expected 20", n_out - out0);
    end
  endtask

  task automatic test_stall_random();
    rdy_mode = 1;
    for (int p = 0; p < 15; p++) begin
      mode = 2'($urandom_range(0, 1));
      send_pkt($urandom_range(2, 6), BW'($urandom), 2'($urandom_range(0, 3)));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    rdy_mode = 2;
    mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      in_data = BW'($urandom); in_keep = BWB'($urandom); in_last = 1'b0; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_in_pkt = 0;
    prev_stall = 0;
    n_checks++;
    if ({out_valid, out_last, out_keep, out_data, busy, in_state_dbg} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: got v=%b d=%h busy=%b st=%0d expected all 0",
               out_valid, out_data, busy, in_state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    send_pkt(3, BW'($urandom), 2'd0);
    drain();
  endtask

  task automatic test_back_to_back();
    rdy_mode = 1;
    for (int p = 0; p < 25; p++) begin
      mode = 2'($urandom_range(0, 3));
      send_pkt($urandom_range(1, 6), BW'($urandom), 2'($urandom_range(0, 3)));
    end
    drain();
  endtask

  initial begin
    hsrc_id = 6'o12;
    fwd_dst = 6'o33;
    mode = 2'd0;
    out_ready = 1'b0;
    test_reset();
    test_echo();
    test_forward();
    test_sink();
    test_full();
    test_stall_random();
    test_reset_mid();
    fwd_dst = 6'($urandom);
    hsrc_id = 6'($urandom);
    test_back_to_back();
`ifdef LOOP_STATS_EN
    n_checks++;
    if (pkt_count !== 32'(m_pkts)) begin
      n_errors++;
      $display("FAIL pkt_count: got %0d expected %0d", pkt_count, m_pkts);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
